// File: rtl/attopu_pkg.sv
// Shared attopu definitions: opcodes, next-PC selects, fetch states.
package attopu_pkg;

  localparam int AW_DEFAULT = 16;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LDA  = 3'b010;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STA  = 3'b100;
  localparam logic [2:0] OP_STR  = 3'b101;
  localparam logic [2:0] OP_BRZ  = 3'b110;
  localparam logic [2:0] OP_BRZR = 3'b111;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_REL = 2'b01;
  localparam int         NPC_REG_BIT = 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_ISSUE = 2'b01,
    S_HALT  = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory side plus decoder/execute side.
// The halted flag exists only when FETCH_HALT_EN is defined.
interface fetch_unit_if import attopu_pkg::*; #(parameter int AW = AW_DEFAULT);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          imem_valid;
  logic [15:0]   instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          exec_ack;
  logic [1:0]    next_pc_sel;
  logic [15:0]   br_addr;
  logic [15:0]   reg_val;
`ifdef FETCH_HALT_EN
  logic          halted;
`endif

  modport master (
`ifdef FETCH_HALT_EN
    output halted,
`endif
    output imem_req, imem_addr, instr, instr_valid, pc,
    input  imem_rdata, imem_valid, exec_ack, next_pc_sel, br_addr, reg_val
  );

  modport slave (
`ifdef FETCH_HALT_EN
    input  halted,
`endif
    input  imem_req, imem_addr, instr, instr_valid, pc,
    output imem_rdata, imem_valid, exec_ack, next_pc_sel, br_addr, reg_val
  );
endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC: sequential, PC-relative or register target, modulo 2^AW.
module npc_calc import attopu_pkg::*; #(
  parameter int AW = AW_DEFAULT
) (
  input  logic [AW-1:0] pc_i,
  input  logic [1:0]    sel_i,
  input  logic [15:0]   br_addr_i,
  input  logic [15:0]   reg_val_i,
  output logic [AW-1:0] npc_o
);

  // Register select is decided on bit 1 alone so an unknown bit 0 cannot leak into the PC.
  always_comb begin
    npc_o = pc_i + AW'(1);
    if (sel_i[NPC_REG_BIT]) begin
      npc_o = reg_val_i[AW-1:0];
    end else if (sel_i == NPC_REL) begin
      npc_o = pc_i + br_addr_i[AW-1:0];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer: FETCH until memory answers, ISSUE until execute acks.
// FETCH_HALT_EN adds a terminal HALT state entered on a branch-to-self.
module fetch_unit import attopu_pkg::*; #(
  parameter int          AW       = AW_DEFAULT,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_t  state_q;
  logic [AW-1:0] pc_q;
  logic [15:0]   instr_q;
  logic [AW-1:0] npc_d;

  npc_calc #(.AW(AW)) u_npc (
    .pc_i      (pc_q),
    .sel_i     (bus.next_pc_sel),
    .br_addr_i (bus.br_addr),
    .reg_val_i (bus.reg_val),
    .npc_o     (npc_d)
  );

`ifdef FETCH_HALT_EN
  logic self_branch;
  assign self_branch = !bus.next_pc_sel[NPC_REG_BIT] && (bus.next_pc_sel == NPC_REL)
                       && (bus.br_addr == 16'h0000);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_valid) begin
            instr_q <= bus.imem_rdata;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.exec_ack) begin
`ifdef FETCH_HALT_EN
            if (self_branch) begin
              state_q <= S_HALT;
            end else begin
              pc_q    <= npc_d;
              state_q <= S_FETCH;
            end
`else
            pc_q    <= npc_d;
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef FETCH_HALT_EN
        S_HALT: state_q <= S_HALT;
`endif
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Request is gated by rst so memory sees nothing while reset is held.
  assign bus.imem_req    = (state_q == S_FETCH) && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == S_ISSUE);
  assign bus.pc          = pc_q;
`ifdef FETCH_HALT_EN
  assign bus.halted      = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a wait-state instruction memory model.
module tb_fetch_unit;
  import attopu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   mem_wait = 0;
  int   mem_cnt;
  logic valid_pulse = 1'b0;

  fetch_unit_if #(.AW(16)) bus();

  fetch_unit #(.AW(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || !bus.imem_req || bus.imem_valid) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  assign bus.imem_valid = (bus.imem_req && (mem_cnt >= mem_wait)) || valid_pulse;
  assign bus.imem_rdata = valid_pulse ? 16'hDEAD : mem_word(bus.imem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.exec_ack = 1'b1;
    bus.next_pc_sel = NPC_SEQ;
    bus.br_addr = 16'h0000;
    bus.reg_val = 16'h0000;
    repeat (3) @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.imem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_ivld got=%b want=0", bus.instr_valid); end
    total++; if (bus.pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", bus.pc); end
    total++; if (bus.instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", bus.instr); end
`ifdef FETCH_HALT_EN
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", bus.halted); end
`endif
    rst = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL release_req got=%b want=1", bus.imem_req); end
  endtask

  // Enters mid-FETCH of pc 0; leaves mid-ISSUE of pc 4.
  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'(i) || bus.instr_valid !== 1'b0) begin
        bad++; $display("FAIL seq_fetch%0d got req=%b addr=%h ivld=%b want 1/%h/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid, 16'(i));
      end
      @(negedge clk);
      total++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== 16'(i) || bus.instr !== mem_word(16'(i))) begin
        bad++; $display("FAIL seq_issue%0d got ivld=%b req=%b pc=%h instr=%h want 1/0/%h/%h", i, bus.instr_valid, bus.imem_req, bus.pc, bus.instr, 16'(i), mem_word(16'(i)));
      end
      @(negedge clk);
    end
    @(negedge clk);
    total++; if (bus.pc !== 16'h0004 || bus.instr_valid !== 1'b1) begin
      bad++; $display("FAIL seq_pc4 got pc=%h ivld=%b want 0004/1", bus.pc, bus.instr_valid);
    end
  endtask

  // All following tasks enter and leave mid-ISSUE with exec_ack high.
  task automatic test_wait_states();
    bus.next_pc_sel = 2'b10;
    bus.reg_val = 16'h0005;
    mem_wait = 3;
    @(negedge clk);
    bus.next_pc_sel = NPC_SEQ;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0005 || bus.instr_valid !== 1'b0) begin
        bad++; $display("FAIL wait_fetch%0d got req=%b addr=%h ivld=%b want 1/0005/0", k, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      @(negedge clk);
    end
    total++; if (bus.instr_valid !== 1'b1 || bus.pc !== 16'h0005 || bus.instr !== mem_word(16'h0005)) begin
      bad++; $display("FAIL wait_issue got ivld=%b pc=%h instr=%h want 1/0005/%h", bus.instr_valid, bus.pc, bus.instr, mem_word(16'h0005));
    end
    mem_wait = 0;
  endtask

  task automatic test_reg_branch_x();
    bus.next_pc_sel = 2'b1x;
    bus.reg_val = 16'h1234;
    @(negedge clk);
    bus.next_pc_sel = NPC_SEQ;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h1234 || $isunknown(bus.pc)) begin
      bad++; $display("FAIL regx_fetch got req=%b addr=%h want 1/1234", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    total++; if (bus.pc !== 16'h1234 || bus.instr_valid !== 1'b1) begin
      bad++; $display("FAIL regx_issue got pc=%h ivld=%b want 1234/1", bus.pc, bus.instr_valid);
    end
  endtask

  task automatic test_rel_branch();
    bus.next_pc_sel = 2'b10;
    bus.reg_val = 16'h0010;
    repeat (2) @(negedge clk);
    total++; if (bus.pc !== 16'h0010 || bus.instr_valid !== 1'b1) begin
      bad++; $display("FAIL rel_setup got pc=%h ivld=%b want 0010/1", bus.pc, bus.instr_valid);
    end
    bus.next_pc_sel = NPC_REL;
    bus.br_addr = 16'hFFFC;
    @(negedge clk);
    bus.next_pc_sel = NPC_SEQ;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h000C) begin
      bad++; $display("FAIL rel_back got req=%b addr=%h want 1/000c", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bus.next_pc_sel = 2'b10;
    bus.reg_val = 16'hFFFF;
    repeat (2) @(negedge clk);
    total++; if (bus.pc !== 16'hFFFF || bus.instr !== mem_word(16'hFFFF)) begin
      bad++; $display("FAIL wrap_setup got pc=%h instr=%h want ffff/%h", bus.pc, bus.instr, mem_word(16'hFFFF));
    end
    bus.next_pc_sel = NPC_SEQ;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      bad++; $display("FAIL wrap_seq got req=%b addr=%h want 1/0000", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
  endtask

  // Stall in ISSUE of pc 0 with stray memory valids; leaves with target 7 set up and memory slowed.
  task automatic test_stall();
    bus.exec_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_pulse = (k % 2 == 0);
      @(negedge clk);
      total++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== 16'h0000 || bus.instr !== mem_word(16'h0000)) begin
        bad++; $display("FAIL stall%0d got ivld=%b req=%b pc=%h instr=%h want 1/0/0000/%h", k, bus.instr_valid, bus.imem_req, bus.pc, bus.instr, mem_word(16'h0000));
      end
    end
    valid_pulse = 1'b0;
    bus.exec_ack = 1'b1;
    bus.next_pc_sel = 2'b10;
    bus.reg_val = 16'h0007;
    mem_wait = 3;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.next_pc_sel = NPC_SEQ;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0007) begin
      bad++; $display("FAIL mid_fetch got req=%b addr=%h want 1/0007", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.pc !== 16'h0000 || bus.instr_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst got req=%b pc=%h ivld=%b want 0/0000/0", bus.imem_req, bus.pc, bus.instr_valid);
    end
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_hold got req=%b want 0", bus.imem_req); end
    rst = 1'b0;
    mem_wait = 0;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      bad++; $display("FAIL mid_refetch got req=%b addr=%h want 1/0000", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem_word(16'h0000)) begin
      bad++; $display("FAIL mid_issue got ivld=%b instr=%h want 1/%h", bus.instr_valid, bus.instr, mem_word(16'h0000));
    end
  endtask

  task automatic test_halt();
    bus.next_pc_sel = 2'b10;
    bus.reg_val = 16'h0009;
    repeat (2) @(negedge clk);
    total++; if (bus.pc !== 16'h0009 || bus.instr_valid !== 1'b1) begin
      bad++; $display("FAIL halt_setup got pc=%h ivld=%b want 0009/1", bus.pc, bus.instr_valid);
    end
    bus.next_pc_sel = NPC_REL;
    bus.br_addr = 16'h0000;
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 16'h0009) begin
        bad++; $display("FAIL halt%0d got halted=%b req=%b ivld=%b pc=%h want 1/0/0/0009", k, bus.halted, bus.imem_req, bus.instr_valid, bus.pc);
      end
    end
`else
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0009) begin
        bad++; $display("FAIL spin_fetch%0d got req=%b addr=%h want 1/0009", k, bus.imem_req, bus.imem_addr);
      end
      @(negedge clk);
      total++; if (bus.instr_valid !== 1'b1 || bus.pc !== 16'h0009) begin
        bad++; $display("FAIL spin_issue%0d got ivld=%b pc=%h want 1/0009", k, bus.instr_valid, bus.pc);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_reg_branch_x();
    test_rel_branch();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch and PC sequencer for the attopu core; sits on the producer side of the instruction decoder.
- Fetches 16-bit words from instruction memory over a req/valid handshake.
- Presents each word to the decoder and holds it until execute acknowledges.
- Computes the next PC from the decoder's nextPCSel/addr outputs and the register-file value.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset.
AW, 16, PC/address width (PC arithmetic is modulo 2^AW).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
imem_req  out  1  fetch request; high only in FETCH.
imem_addr  out  AW  fetch address; equals pc.
imem_rdata  in  16  instruction word from memory.
imem_valid  in  1  rdata valid; sampled only while imem_req=1.
instr  out  16  latched instruction to decoder.
instr_valid  out  1  instr is valid; high only in ISSUE.
pc  out  AW  address of the instruction in instr.
exec_ack  in  1  execute consumed instr; sampled only while instr_valid=1.
next_pc_sel  in  2  from decoder: 00 sequential, 01 relative, 1x register.
br_addr  in  16  from decoder: sign-extended relative offset.
reg_val  in  16  register-file read port 1 value (register branch target).

Behaviour:
- Reset value of every output while rst=1:
  - state=FETCH, pc=RESET_PC, instr=16'h0000.
  - instr_valid=0, imem_req=0.
  - imem_req is gated by rst.
- Release of reset: imem_req rises in the first cycle with rst low.
- States:
  - FETCH: imem_req=1, imem_addr=pc. If imem_valid, then instr<=imem_rdata, go to ISSUE. Otherwise stay, holding req and addr stable.
  - ISSUE: instr_valid=1, instr/pc held. If exec_ack, then pc<=npc, go to FETCH. Otherwise stay; imem_valid is ignored.
- npc (combinational, AW-bit wrap):
  - 00 -> pc+1.
  - 01 -> pc+br_addr. Offset is relative to the branch's own address.
  - 1x -> reg_val[AW-1:0]. Decided on bit 1 only; bit 0 is don't-care and may be X.
- Wrap-around: pc=16'hFFFF with sel 00 -> 16'h0000. Relative targets wrap modulo 2^AW with no overflow flag.
- Latency: minimum 2 cycles per instruction (1 FETCH with same-cycle imem_valid, plus 1 ISSUE with same-cycle exec_ack). Memory wait states and execute stalls extend FETCH and ISSUE 1:1.
- Simultaneous events:
  - imem_valid while in ISSUE is ignored; the memory must not respond without req.
  - exec_ack while in FETCH is ignored.
- Reset mid-operation: pc returns to RESET_PC, and any in-flight fetch is abandoned. Memory shares rst and drops its pending response.
- instr, pc and next_pc_sel are stable for the whole ISSUE period. The decoder output is sampled only on the exec_ack edge.

Optional Feature:
Macro: FETCH_HALT_EN.
- Defined:
  - Adds output `halted` (1 bit, reset 0) and state HALT.
  - Entered from ISSUE when exec_ack=1, next_pc_sel=01 and br_addr=0 (branch-to-self, the program end idiom).
  - In HALT: imem_req=0, instr_valid=0, halted=1, pc frozen. Left only by rst.
- Undefined:
  - No halted port.
  - Branch-to-self refetches the same pc forever (spin), using the ordinary FETCH/ISSUE path.

Decomposition:
- Package attopu_pkg:
  - opcode constants (ALU 000, LDA 010, LDR 011, STA 100, STR 101, BRZ 110, BRZR 111).
  - next-PC select constants NPC_SEQ=2'b00, NPC_REL=2'b01, NPC_REG bit1=1.
  - state encoding FETCH/ISSUE/HALT; AW default.
- Sub-module npc_calc: combinational next-PC mux plus adder (inputs pc, sel, br_addr, reg_val; output npc). Reused by the verification reference model.

Test Plan:
- Reset, RESET_PC=0, memory zero-wait, exec_ack tied 1, sel=00 -> imem_addr 0,1,2,3 on alternate cycles; instr_valid toggles 0/1.
- Memory 3 wait states at pc=5 -> imem_req held 4 cycles with imem_addr=5 stable; instr_valid rises the cycle after imem_valid.
- At pc=16'h0010, sel=01, br_addr=16'hFFFC -> next imem_addr=16'h000C. At pc=16'hFFFF, sel=00 -> next imem_addr=16'h0000.
- sel=2'b1x (bit0=X), reg_val=16'h1234 -> next imem_addr=16'h1234 with no X propagation on pc.
- exec_ack held low 5 cycles in ISSUE with imem_valid pulsed -> instr/pc unchanged, no fetch issued. Assert rst mid-FETCH at pc=7 -> imem_req=0 during reset, then refetch at RESET_PC.
- FETCH_HALT_EN defined: sel=01, br_addr=0, exec_ack at pc=9 -> halted=1, imem_req stays 0, pc=9. Undefined: same stimulus -> repeated fetches of 9.
